// File: rtl/lut_sweep_ctrl.sv
// Sweeps every input combination of a truth-table gate, captures its output and compares against a loaded table.
// Latency: start to done is 2^N_IN*(SETTLE+1) cycles; each combination is held SETTLE+1 cycles before sampling.
// Backpressure: cfg_ready is high only in IDLE; cfg/start are ignored while sweeping, abort is ignored while idle.
module lut_sweep_ctrl #(
   parameter int  N_IN   = 2,
   parameter int  SETTLE = 1,
   localparam int TT_W   = 1 << N_IN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [TT_W-1:0] cfg_data,
   input  logic            start,
   input  logic            abort,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic [TT_W-1:0] measured,
   output logic            match,
   output logic [N_IN-1:0] fail_idx
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
   localparam logic [N_IN-1:0] IDX_LAST   = {N_IN{1'b1}};

   state_t          state_q, state_d;
   logic [TT_W-1:0] expected_q, expected_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [3:0]      wait_cnt_q, wait_cnt_d;
   logic [N_IN-1:0] dut_in_q, dut_in_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [TT_W-1:0] measured_q, measured_d;
   logic            match_q, match_d;
   logic [N_IN-1:0] fail_idx_q, fail_idx_d;

   // Captured table with the bit being sampled on this edge already merged in,
   // so the final compare sees the complete table.
   logic [TT_W-1:0] meas_sample;
   logic [TT_W-1:0] diff;
   logic [N_IN-1:0] first_diff;

   // Merge the live gate output into the captured table at the current index.
   always_comb begin
      meas_sample        = measured_q;
      meas_sample[idx_q] = dut_out;
   end

   // Lowest mismatching row wins; zero when the tables agree.
   always_comb begin
      diff       = meas_sample ^ expected_q;
      first_diff = '0;
      for (int i = TT_W - 1; i >= 0; i--) begin
         if (diff[i]) begin
            first_diff = N_IN'(i);
         end
      end
   end

   // Next-state and register updates for the IDLE/SWEEP sequencer.
   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      idx_d      = idx_q;
      wait_cnt_d = wait_cnt_q;
      dut_in_d   = dut_in_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      measured_d = measured_q;
      match_d    = match_q;
      fail_idx_d = fail_idx_q;

      case (state_q)
         ST_IDLE: begin
            // A table offered alongside start is the one the sweep compares against.
            if (cfg_valid) begin
               expected_d = cfg_data;
            end
            if (start) begin
               state_d    = ST_SWEEP;
               idx_d      = '0;
               dut_in_d   = '0;
               wait_cnt_d = SETTLE_CNT;
               busy_d     = 1'b1;
               measured_d = '0;
               match_d    = 1'b0;
               fail_idx_d = '0;
            end
         end

         ST_SWEEP: begin
            if (abort) begin
               // Partial capture is left visible for debug.
               state_d    = ST_IDLE;
               busy_d     = 1'b0;
               match_d    = 1'b0;
               dut_in_d   = '0;
               idx_d      = '0;
               wait_cnt_d = '0;
            end else if (wait_cnt_q != 4'd0) begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end else begin
               measured_d = meas_sample;
               if (idx_q == IDX_LAST) begin
                  state_d    = ST_IDLE;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  dut_in_d   = '0;
                  idx_d      = '0;
                  match_d    = (diff == '0);
                  fail_idx_d = first_diff;
               end else begin
                  idx_d      = idx_q + 1'b1;
                  dut_in_d   = idx_q + 1'b1;
                  wait_cnt_d = SETTLE_CNT;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         expected_q <= '0;
         idx_q      <= '0;
         wait_cnt_q <= '0;
         dut_in_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         measured_q <= '0;
         match_q    <= 1'b0;
         fail_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         idx_q      <= idx_d;
         wait_cnt_q <= wait_cnt_d;
         dut_in_q   <= dut_in_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         measured_q <= measured_d;
         match_q    <= match_d;
         fail_idx_q <= fail_idx_d;
      end
   end

   assign cfg_ready = (state_q == ST_IDLE);
   assign dut_in    = dut_in_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign measured  = measured_q;
   assign match     = match_q;
   assign fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// Bench for lut_sweep_ctrl: two instances (N_IN=2/SETTLE=1 and N_IN=3/SETTLE=0) each driving a table-driven gate.
// A cycle-level reference derived from the sweep timing rules is compared against both instances every cycle.
// Directed scenarios pin literal results; a randomized phase follows.
module tb_lut_sweep_ctrl;

   logic clk = 1'b0;
   logic rst;

   // Clock generation.
   always #5 clk = ~clk;

   int ni [2] = '{2, 3};
   int st [2] = '{1, 0};

   logic        i_cfg_valid [2];
   logic        i_start     [2];
   logic        i_abort     [2];
   logic [15:0] i_cfg       [2];
   logic [15:0] gate        [2];

   logic       cfg_ready0, busy0, done0, match0, g_out0;
   logic [1:0] dut_in0, fidx0;
   logic [3:0] meas0;
   logic       cfg_ready1, busy1, done1, match1, g_out1;
   logic [2:0] dut_in1, fidx1;
   logic [7:0] meas1;

   // The gates under test: pure truth-table lookups.
   assign g_out0 = gate[0][dut_in0];
   assign g_out1 = gate[1][dut_in1];

   lut_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u_dut0 (
      .clk(clk), .rst(rst),
      .cfg_valid(i_cfg_valid[0]), .cfg_ready(cfg_ready0), .cfg_data(i_cfg[0][3:0]),
      .start(i_start[0]), .abort(i_abort[0]),
      .dut_in(dut_in0), .dut_out(g_out0),
      .busy(busy0), .done(done0), .measured(meas0), .match(match0), .fail_idx(fidx0)
   );

   lut_sweep_ctrl #(.N_IN(3), .SETTLE(0)) u_dut1 (
      .clk(clk), .rst(rst),
      .cfg_valid(i_cfg_valid[1]), .cfg_ready(cfg_ready1), .cfg_data(i_cfg[1][7:0]),
      .start(i_start[1]), .abort(i_abort[1]),
      .dut_in(dut_in1), .dut_out(g_out1),
      .busy(busy1), .done(done1), .measured(meas1), .match(match1), .fail_idx(fidx1)
   );

   logic        o_rdy [2], o_busy [2], o_done [2], o_match [2];
   logic [3:0]  o_din [2], o_fidx [2];
   logic [15:0] o_meas [2];

   // Gather both instances' outputs into common-width arrays.
   always_comb begin
      o_rdy[0] = cfg_ready0; o_busy[0] = busy0; o_done[0] = done0; o_match[0] = match0;
      o_din[0] = 4'(dut_in0); o_fidx[0] = 4'(fidx0); o_meas[0] = 16'(meas0);
      o_rdy[1] = cfg_ready1; o_busy[1] = busy1; o_done[1] = done1; o_match[1] = match1;
      o_din[1] = 4'(dut_in1); o_fidx[1] = 4'(fidx1); o_meas[1] = 16'(meas1);
   end

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // c counts edges since the accepting edge E0; combination k is sampled at
   // c = (k+1)*(SETTLE+1), and after edge c the drive is floor(c/(SETTLE+1)).
   bit          m_busy [2], m_done [2], m_match [2];
   int          m_c [2], m_din [2], m_fidx [2];
   logic [15:0] m_exp [2], m_meas [2];

   task automatic model_step(int u);
      int          s1;
      int          tt;
      int          k;
      int          f;
      logic [15:0] d;
      s1 = st[u] + 1;
      tt = 1 << ni[u];
      if (rst) begin
         m_busy[u] = 0; m_done[u] = 0; m_match[u] = 0; m_c[u] = 0;
         m_din[u] = 0; m_fidx[u] = 0; m_exp[u] = '0; m_meas[u] = '0;
         return;
      end
      m_done[u] = 0;
      if (!m_busy[u]) begin
         if (i_cfg_valid[u]) m_exp[u] = i_cfg[u] & 16'((32'd1 << tt) - 1);
         if (i_start[u]) begin
            m_busy[u] = 1; m_c[u] = 0; m_meas[u] = '0; m_match[u] = 0; m_fidx[u] = 0; m_din[u] = 0;
         end
      end else if (i_abort[u]) begin
         m_busy[u] = 0; m_din[u] = 0; m_match[u] = 0;
      end else begin
         m_c[u]++;
         if (m_c[u] % s1 == 0) begin
            k = m_c[u] / s1 - 1;
            m_meas[u][k] = gate[u][k];
            if (k == tt - 1) begin
               m_busy[u] = 0; m_done[u] = 1; m_din[u] = 0;
               d = m_meas[u] ^ m_exp[u];
               m_match[u] = (d == 16'd0);
               f = 0;
               while (f < tt && !d[f]) f++;
               m_fidx[u] = (f == tt) ? 0 : f;
            end else begin
               m_din[u] = m_c[u] / s1;
            end
         end
      end
   endtask

   // Advance the reference on every rising edge from the same sampled inputs as the DUTs.
   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   // Compare every output of both instances against the reference, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d.busy", u), 32'(o_busy[u]), 32'(m_busy[u]));
            check($sformatf("u%0d.cfg_ready", u), 32'(o_rdy[u]), 32'(!m_busy[u]));
            check($sformatf("u%0d.done", u), 32'(o_done[u]), 32'(m_done[u]));
            check($sformatf("u%0d.dut_in", u), 32'(o_din[u]), 32'(m_din[u]));
            check($sformatf("u%0d.measured", u), 32'(o_meas[u]), 32'(m_meas[u]));
            check($sformatf("u%0d.match", u), 32'(o_match[u]), 32'(m_match[u]));
            check($sformatf("u%0d.fail_idx", u), 32'(o_fidx[u]), 32'(m_fidx[u]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(negedge clk);
   endtask

   // Offer a table (optionally) and start together, then run past completion.
   task automatic run_literal(int u, bit load, logic [15:0] cfg, logic [15:0] x_meas,
                              logic x_match, int x_fidx, int x_done_at, string tag);
      int dcnt;
      int dat;
      dcnt = 0;
      dat  = -1;
      i_cfg_valid[u] = load; i_cfg[u] = cfg; i_start[u] = 1'b1;
      cyc();
      i_cfg_valid[u] = 1'b0; i_start[u] = 1'b0;
      check({tag, ".busy_at_E0"}, 32'(o_busy[u]), 32'd1);
      check({tag, ".dut_in_at_E0"}, 32'(o_din[u]), 32'd0);
      for (int c = 1; c <= x_done_at + 2; c++) begin
         cyc();
         if (o_done[u]) begin
            dcnt++;
            dat = c;
         end
         if (c == x_done_at) begin
            check({tag, ".measured"}, 32'(o_meas[u]), 32'(x_meas));
            check({tag, ".match"}, 32'(o_match[u]), 32'(x_match));
            check({tag, ".fail_idx"}, 32'(o_fidx[u]), 32'(x_fidx));
            check({tag, ".busy_at_done"}, 32'(o_busy[u]), 32'd0);
         end
      end
      check({tag, ".done_count"}, 32'(dcnt), 32'd1);
      check({tag, ".done_edge"}, 32'(dat), 32'(x_done_at));
   endtask

   initial begin
      int dcnt;
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         i_cfg_valid[u] = 1'b0; i_start[u] = 1'b0; i_abort[u] = 1'b0; i_cfg[u] = '0;
      end
      gate[0] = 16'h000D;   // rows 0..3 -> 1,0,1,1
      gate[1] = 16'h00E8;   // 3-input majority
      repeat (2) cyc();
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state.
      for (int u = 0; u < 2; u++) begin
         check("reset.cfg_ready", 32'(o_rdy[u]), 32'd1);
         check("reset.busy", 32'(o_busy[u]), 32'd0);
         check("reset.done", 32'(o_done[u]), 32'd0);
         check("reset.match", 32'(o_match[u]), 32'd0);
         check("reset.measured", 32'(o_meas[u]), 32'd0);
      end

      // Matching table, mismatching tables.
      run_literal(0, 1'b1, 16'h000D, 16'h000D, 1'b1, 0, 8, "t1");
      run_literal(0, 1'b1, 16'h0008, 16'h000D, 1'b0, 0, 8, "t2_and");
      run_literal(0, 1'b1, 16'h000F, 16'h000D, 1'b0, 1, 8, "t2_ones");

      // Abort taken on edge E0+4 with an all-ones gate.
      gate[0] = 16'h000F;
      i_start[0] = 1'b1;
      cyc();
      i_start[0] = 1'b0;
      repeat (3) cyc();
      i_abort[0] = 1'b1;
      cyc();
      i_abort[0] = 1'b0;
      check("abort.busy", 32'(o_busy[0]), 32'd0);
      check("abort.cfg_ready", 32'(o_rdy[0]), 32'd1);
      check("abort.match", 32'(o_match[0]), 32'd0);
      check("abort.measured", 32'(o_meas[0]), 32'h1);
      dcnt = 0;
      for (int c = 0; c < 12; c++) begin
         cyc();
         if (o_done[0]) dcnt++;
      end
      check("abort.no_done", 32'(dcnt), 32'd0);
      gate[0] = 16'h000D;

      // Busy protection: start and a zero table offered mid-sweep are ignored.
      i_cfg_valid[0] = 1'b1; i_cfg[0] = 16'h000D; i_start[0] = 1'b1;
      cyc();
      i_cfg_valid[0] = 1'b0; i_start[0] = 1'b0;
      repeat (2) cyc();
      i_cfg_valid[0] = 1'b1; i_cfg[0] = 16'h0000; i_start[0] = 1'b1;
      cyc();
      check("busyprot.cfg_ready", 32'(o_rdy[0]), 32'd0);
      cyc();
      i_cfg_valid[0] = 1'b0; i_start[0] = 1'b0;
      dcnt = 0;
      for (int c = 5; c <= 12; c++) begin
         cyc();
         if (o_done[0]) dcnt++;
         if (c == 8) begin
            check("busyprot.done_at_8", 32'(o_done[0]), 32'd1);
            check("busyprot.match", 32'(o_match[0]), 32'd1);
         end
      end
      check("busyprot.done_count", 32'(dcnt), 32'd1);

      // Three-input majority, SETTLE=0.
      run_literal(1, 1'b1, 16'h00E8, 16'h00E8, 1'b1, 0, 8, "t5_maj");
      run_literal(1, 1'b1, 16'h00E9, 16'h00E8, 1'b0, 0, 8, "t5_bad");

      // Reset mid-sweep at E0+5.
      i_cfg_valid[0] = 1'b1; i_cfg[0] = 16'h000D; i_start[0] = 1'b1;
      cyc();
      i_cfg_valid[0] = 1'b0; i_start[0] = 1'b0;
      repeat (4) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rst.busy", 32'(o_busy[0]), 32'd0);
      check("rst.done", 32'(o_done[0]), 32'd0);
      check("rst.dut_in", 32'(o_din[0]), 32'd0);
      check("rst.measured", 32'(o_meas[0]), 32'd0);
      check("rst.cfg_ready", 32'(o_rdy[0]), 32'd1);
      // Cleared expected table: a sweep without loading compares against zero.
      run_literal(0, 1'b0, 16'h0000, 16'h000D, 1'b0, 0, 8, "rst_noload");
      run_literal(0, 1'b1, 16'h000D, 16'h000D, 1'b1, 0, 8, "rst_fresh");

      // Randomized traffic, checked by the per-cycle reference.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 499) == 0);
         for (int u = 0; u < 2; u++) begin
            i_start[u]     = ($urandom_range(0, 3) == 0);
            i_abort[u]     = ($urandom_range(0, 15) == 0);
            i_cfg_valid[u] = $urandom_range(0, 1) == 1;
            i_cfg[u]       = ($urandom_range(0, 1) == 1) ? gate[u] : 16'($urandom);
            if (!m_busy[u] && !i_start[u] && $urandom_range(0, 7) == 0) begin
               gate[u] = 16'($urandom);
            end
         end
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
